axis_traffic_gen: RTL and testbench

//  Parametrised AXI-Stream traffic endpoint for mesh NoC benches and on-chip self-test.

---
 rtl/axis_traffic_gen.sv | 109 ++++++++++
 tb/tb_axis_traffic_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: AXI-Stream LFSR traffic source with round-robin destinations and a counting/XOR sink
module axis_traffic_gen #(
  parameter int                 TDATAW         = 32,
  parameter int                 TDESTW         = 4,
  parameter int                 LFSR_DW        = 8,
  parameter logic [LFSR_DW-1:0] LFSR_DEFAULT   = 8'h01,
  parameter logic [LFSR_DW-1:0] LFSR_TAPS      = 8'hB8,
  parameter int                 NUM_PACKETS    = 16,
  parameter int                 PKT_LEN        = 4,
  parameter int                 NUM_DESTS      = 2,
  parameter int                 DEST_BASE      = 0,
  parameter int                 EXPECT_PACKETS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  output logic [15:0]       rx_pkt_cnt,
  output logic [TDATAW-1:0] rx_xor,
  output logic              axis_m_tvalid,
  input  logic              axis_m_tready,
  output logic [TDATAW-1:0] axis_m_tdata,
  output logic              axis_m_tlast,
  output logic [TDESTW-1:0] axis_m_tdest,
  input  logic              axis_s_tvalid,
  output logic              axis_s_tready,
  input  logic [TDATAW-1:0] axis_s_tdata,
  input  logic              axis_s_tlast,
  input  logic [TDESTW-1:0] axis_s_tdest
);
  localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam int PW = NUM_PACKETS > 1 ? $clog2(NUM_PACKETS) : 1;
  localparam int DW = NUM_DESTS > 1 ? $clog2(NUM_DESTS) : 1;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, FIN} state_t;
  state_t state, state_nxt;
  logic [LFSR_DW-1:0] lfsr;
  logic [BW-1:0] beat;
  logic [PW-1:0] pkt;
  logic [DW-1:0] dest_idx;
  logic go, xfer, beat_last, pkt_last, dest_last, rx_xfer;
  logic unused_tdest;
  assign go            = start & (state == IDLE | state == FIN);
  assign xfer          = axis_m_tvalid & axis_m_tready;
  assign beat_last     = beat == BW'(PKT_LEN - 1);
  assign pkt_last      = pkt == PW'(NUM_PACKETS - 1);
  assign dest_last     = dest_idx == DW'(NUM_DESTS - 1);
  assign rx_xfer       = axis_s_tvalid & axis_s_tready;
  assign axis_m_tvalid = state == SEND;
  assign axis_m_tlast  = axis_m_tvalid & beat_last;
  assign axis_m_tdata  = axis_m_tvalid ? TDATAW'(lfsr) : '0;
  assign axis_m_tdest  = TDESTW'(DEST_BASE) + TDESTW'(dest_idx);
  assign unused_tdest  = ^axis_s_tdest;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // next-state: run, drain until enough packets return, then hold done
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = go ? SEND : IDLE;
      SEND:    state_nxt = (xfer & beat_last & pkt_last) ? WAIT_RX : SEND;
      WAIT_RX: state_nxt = rx_pkt_cnt >= 16'(EXPECT_PACKETS) ? FIN : WAIT_RX;
      FIN:     state_nxt = go ? SEND : FIN;
      default: state_nxt = IDLE;
    endcase
  end
  // generator: LFSR payload, beat/packet/destination counters advance per transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= LFSR_DEFAULT;
      beat     <= '0;
      pkt      <= '0;
      dest_idx <= '0;
    end else if (go) begin
      lfsr     <= LFSR_DEFAULT;
      beat     <= '0;
      pkt      <= '0;
      dest_idx <= '0;
    end else if (xfer) begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
      beat <= beat_last ? '0 : beat + 1'b1;
      if (beat_last) begin
        pkt      <= pkt_last ? '0 : pkt + 1'b1;
        dest_idx <= dest_last ? '0 : dest_idx + 1'b1;
      end
    end
  end
  // sink: never backpressures; a start clear beats a same-cycle receive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axis_s_tready <= 1'b0;
      done          <= 1'b0;
      rx_pkt_cnt    <= '0;
      rx_xor        <= '0;
    end else begin
      axis_s_tready <= 1'b1;
      done          <= !go & (state == FIN);
      if (go) begin
        rx_pkt_cnt <= '0;
        rx_xor     <= '0;
      end else if (rx_xfer) begin
        rx_xor <= rx_xor ^ axis_s_tdata;
        if (axis_s_tlast && rx_pkt_cnt != 16'hFFFF) rx_pkt_cnt <= rx_pkt_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axis_traffic_gen.sv
// tb_axis_traffic_gen: randomized checks of two generator configurations against a beat-list model
module tb_axis_traffic_gen;
  logic clk = 0, rst_n = 0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  logic start0 = 0, rdy0 = 1, done0, m0_tvalid, m0_tlast, s0_tready;
  logic [31:0] m0_tdata, rx_xor0;
  logic [3:0] m0_tdest;
  logic [15:0] rx_cnt0;
  logic start1 = 0, rdy1 = 1, done1, m1_tvalid, m1_tlast, s1_tready, s1_tvalid = 0, s1_tlast = 0;
  logic [31:0] m1_tdata, rx_xor1, s1_tdata = 0;
  logic [3:0] m1_tdest;
  logic [15:0] rx_cnt1;
  int idx0 = 0, idx1 = 0;
  axis_traffic_gen #(.NUM_PACKETS(2), .PKT_LEN(4), .NUM_DESTS(2), .DEST_BASE(0), .EXPECT_PACKETS(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .done(done0), .rx_pkt_cnt(rx_cnt0), .rx_xor(rx_xor0),
    .axis_m_tvalid(m0_tvalid), .axis_m_tready(rdy0), .axis_m_tdata(m0_tdata), .axis_m_tlast(m0_tlast),
    .axis_m_tdest(m0_tdest), .axis_s_tvalid(m0_tvalid & rdy0), .axis_s_tready(s0_tready),
    .axis_s_tdata(m0_tdata), .axis_s_tlast(m0_tlast), .axis_s_tdest(m0_tdest));
  axis_traffic_gen #(.NUM_PACKETS(4), .PKT_LEN(1), .NUM_DESTS(3), .DEST_BASE(5), .EXPECT_PACKETS(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .done(done1), .rx_pkt_cnt(rx_cnt1), .rx_xor(rx_xor1),
    .axis_m_tvalid(m1_tvalid), .axis_m_tready(rdy1), .axis_m_tdata(m1_tdata), .axis_m_tlast(m1_tlast),
    .axis_m_tdest(m1_tdest), .axis_s_tvalid(s1_tvalid), .axis_s_tready(s1_tready),
    .axis_s_tdata(s1_tdata), .axis_s_tlast(s1_tlast), .axis_s_tdest(4'd0));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // payload of beat n: seed stepped n times by the Galois rule
  function automatic logic [31:0] lfsr_at(input int n);
    logic [7:0] v = 8'h01;
    for (int i = 0; i < n; i++) v = {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
    return {24'd0, v};
  endfunction
  function automatic logic [31:0] xor_upto(input int n);
    logic [31:0] x = 0;
    for (int i = 0; i < n; i++) x ^= lfsr_at(i);
    return x;
  endfunction
  // every presented beat (stalled or not) must equal model beat idx; idx advances on transfer
  always @(negedge clk) begin
    if (start0) idx0 = 0;
    else if (rst_n && m0_tvalid) begin
      if (idx0 >= 8) chk("m0_extra_beat", 1, 0);
      else begin
        chk("m0_data", m0_tdata, lfsr_at(idx0));
        chk("m0_last", {31'd0, m0_tlast}, {31'd0, idx0 % 4 == 3});
        chk("m0_dest", {28'd0, m0_tdest}, (idx0 / 4) % 2);
        if (rdy0) idx0++;
      end
    end
  end
  always @(negedge clk) begin
    if (start1) idx1 = 0;
    else if (rst_n && m1_tvalid) begin
      if (idx1 >= 4) chk("m1_extra_beat", 1, 0);
      else begin
        chk("m1_data", m1_tdata, lfsr_at(idx1));
        chk("m1_last", {31'd0, m1_tlast}, 1);
        chk("m1_dest", {28'd0, m1_tdest}, 5 + idx1 % 3);
        if (rdy1) idx1++;
      end
    end
  end
  task automatic start_u0();
    start0 = 1;
    @(posedge clk); #1;
    start0 = 0;
    chk("start_done_clr", {31'd0, done0}, 0);
    chk("start_cnt_clr", {16'd0, rx_cnt0}, 0);
    chk("start_xor_clr", rx_xor0, 0);
  endtask
  task automatic run_u0(input bit rnd);
    int c = 0;
    while (!done0 && c < 400) begin
      @(posedge clk); #1;
      if (rnd) rdy0 = 1'($urandom_range(0, 1));
      c++;
    end
    rdy0 = 1;
    chk("u0_done", {31'd0, done0}, 1);
    chk("u0_beats", idx0, 8);
    chk("u0_rx_cnt", {16'd0, rx_cnt0}, 2);
    chk("u0_rx_xor", rx_xor0, xor_upto(8));
  endtask
  initial begin
    logic [31:0] x, d;
    #3;
    chk("rst_valid", {31'd0, m0_tvalid}, 0);
    chk("rst_last", {31'd0, m0_tlast}, 0);
    chk("rst_data", m0_tdata, 0);
    chk("rst_dest0", {28'd0, m0_tdest}, 0);
    chk("rst_dest1", {28'd0, m1_tdest}, 5);
    chk("rst_done", {31'd0, done0}, 0);
    chk("rst_cnt", {16'd0, rx_cnt0}, 0);
    chk("rst_xor", rx_xor0, 0);
    chk("rst_sready", {31'd0, s0_tready}, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("sready_up", {31'd0, s0_tready}, 1);
    start_u0();
    run_u0(0);
    repeat (3) @(posedge clk);
    #1 chk("done_held", {31'd0, done0}, 1);
    start_u0();
    run_u0(1);
    start_u0();
    for (int c = 0; c < 40 && idx0 != 2; c++) begin @(negedge clk); #1; end
    chk("mid_reached", idx0, 2);
    @(posedge clk); #2;
    chk("mid_beat2", m0_tdata, lfsr_at(2));
    rst_n = 0;
    #1;
    chk("arst_valid", {31'd0, m0_tvalid}, 0);
    chk("arst_last", {31'd0, m0_tlast}, 0);
    chk("arst_data", m0_tdata, 0);
    chk("arst_dest", {28'd0, m0_tdest}, 0);
    chk("arst_cnt", {16'd0, rx_cnt0}, 0);
    chk("arst_xor", rx_xor0, 0);
    chk("arst_sready", {31'd0, s0_tready}, 0);
    @(negedge clk) rst_n = 1;
    repeat (2) @(posedge clk);
    #1 start_u0();
    run_u0(0);
    x = $urandom;
    s1_tvalid = 1; s1_tlast = 1; s1_tdata = x;
    @(posedge clk); #1;
    s1_tvalid = 0;
    chk("pre_cnt", {16'd0, rx_cnt1}, 1);
    chk("pre_xor", rx_xor1, x);
    start1 = 1; s1_tvalid = 1; s1_tdata = $urandom;
    @(posedge clk); #1;
    start1 = 0; s1_tvalid = 0;
    chk("clr_cnt", {16'd0, rx_cnt1}, 0);
    chk("clr_xor", rx_xor1, 0);
    for (int c = 0; c < 40 && idx1 != 4; c++) begin @(posedge clk); #1; end
    chk("u1_beats", idx1, 4);
    repeat (10) @(posedge clk);
    #1 chk("wait_no_done", {31'd0, done1}, 0);
    x = 0;
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      x ^= d;
      s1_tvalid = 1; s1_tdata = d;
      @(posedge clk); #1;
    end
    s1_tvalid = 0;
    chk("inj_cnt", {16'd0, rx_cnt1}, 3);
    chk("inj_xor", rx_xor1, x);
    chk("done_lat0", {31'd0, done1}, 0);
    @(posedge clk); #1;
    chk("done_lat1", {31'd0, done1}, 0);
    @(posedge clk); #1;
    chk("done_lat2", {31'd0, done1}, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
